// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, fetches bytes over req/ack, issues via valid/ready.
// Define FETCH_TRACE_EN for a simulation trace of accepts and HALT entry.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OPCODE = 4'b0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  IMemReq,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  input  logic                  IMemAck,
  input  logic [7:0]            IMemData,
  output logic [7:0]            Instruction,
  output logic [ADDR_WIDTH-1:0] InstrPC,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  input  logic                  BranchTaken,
  input  logic [3:0]            BranchOffset,
  output logic                  Halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  accept;
  logic                  is_halt;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] br_pc;
  logic [ADDR_WIDTH-1:0] next_pc;

  assign accept  = (state == ISSUE) && InstrReady;
  assign is_halt = Instruction[7:4] == HALT_OPCODE;
  assign seq_pc  = InstrPC + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign br_pc   = InstrPC
                 + {{(ADDR_WIDTH-4){BranchOffset[3]}}, BranchOffset};
  assign next_pc = BranchTaken ? br_pc : seq_pc;

  // Handshake outputs come straight from state, never from inputs.
  assign IMemReq    = state == FETCH;
  assign IMemAddr   = pc;
  assign InstrValid = state == ISSUE;
  assign Halted     = state == HALTED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      Instruction <= 8'h00;
      InstrPC     <= '0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (IMemAck) begin
            Instruction <= IMemData;
            InstrPC     <= pc;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (is_halt) begin
              state <= HALTED;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALTED: state <= HALTED;
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && accept) begin
      $display("%0t fetch pc=%0h instr=%0h bt=%0b next=%0h",
               $time, InstrPC, Instruction, BranchTaken,
               is_halt ? pc : next_pc);
      if (is_halt)
        $display("HALT at %0h", InstrPC);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random + directed stimulus against a
// transaction-level model of the fetch unit.
module tb_instruction_fetch;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_ISSUE = 2;
  localparam int M_HALT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IMemReq;
  logic [7:0] IMemAddr;
  logic       IMemAck = 1'b0;
  logic [7:0] IMemData = 8'h00;
  logic [7:0] Instruction;
  logic [7:0] InstrPC;
  logic       InstrValid;
  logic       InstrReady = 1'b0;
  logic       BranchTaken = 1'b0;
  logic [3:0] BranchOffset = 4'h0;
  logic       Halted;

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .BranchTaken (BranchTaken),
    .BranchOffset(BranchOffset),
    .Halted      (Halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: where fetch is, what is on offer, and next address.
  int         m = M_IDLE;
  int         pc = 0;
  int         ipc = 0;
  int         lat = 0;
  logic [7:0] instr = 8'h00;
  logic [7:0] mem [256];
  bit         br_en [256];
  logic [3:0] br_off [256];
  int         lat_max = 0;
  int         ready_pct = 100;
  bit         dir_mode = 1'b1;
  bit         wrapped = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int next_addr(input int from, input bit bt,
                                   input logic [3:0] off);
    int d;
    if (!bt) d = 1;
    else d = off[3] ? int'(off) - 16 : int'(off);
    return ((from + d) % 256 + 256) % 256;
  endfunction

  // Called at a falling edge: check outputs, drive inputs, advance model.
  task automatic step();
    bit rdy;
    bit acc;
    bit ack;
    check("req", 32'(IMemReq), 32'(m == M_FETCH));
    check("valid", 32'(InstrValid), 32'(m == M_ISSUE));
    check("halted", 32'(Halted), 32'(m == M_HALT));
    if (m == M_FETCH) check("addr", 32'(IMemAddr), pc);
    if (m == M_ISSUE) begin
      check("instr", 32'(Instruction), 32'(instr));
      check("ipc", 32'(InstrPC), ipc);
    end
    rdy = $urandom_range(99) < ready_pct;
    acc = (m == M_ISSUE) && rdy;
    if (m == M_FETCH) ack = (lat == 0);
    else ack = 1'($urandom_range(1));
    InstrReady = rdy;
    IMemAck    = ack;
    IMemData   = (m == M_FETCH && ack) ? mem[IMemAddr] : 8'($urandom);
    if (acc && dir_mode) begin
      BranchTaken  = br_en[ipc];
      BranchOffset = br_off[ipc];
      br_en[ipc]   = 1'b0;
      if (ipc == 8'hFC) wrapped = 1'b1;
    end else begin
      BranchTaken  = 1'($urandom_range(1));
      BranchOffset = 4'($urandom);
    end
    case (m)
      M_IDLE: begin
        m   = M_FETCH;
        lat = $urandom_range(lat_max);
      end
      M_FETCH: begin
        if (lat == 0) begin
          instr = mem[pc];
          ipc   = pc;
          m     = M_ISSUE;
        end else begin
          lat--;
        end
      end
      M_ISSUE: begin
        if (acc) begin
          if (instr[7:4] == 4'h1) begin
            m = M_HALT;
          end else begin
            pc  = next_addr(ipc, BranchTaken, BranchOffset);
            m   = M_FETCH;
            lat = $urandom_range(lat_max);
          end
        end
      end
      default: m = M_HALT;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(IMemReq), 0);
    check("rst_valid", 32'(InstrValid), 0);
    check("rst_halted", 32'(Halted), 0);
    check("rst_instr", 32'(Instruction), 0);
    check("rst_ipc", 32'(InstrPC), 0);
    check("rst_addr", 32'(IMemAddr), 0);
    m = M_IDLE;
    pc = 0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]    = (a[7:4] == 4'h1) ? {4'h2, a[3:0]} : 8'(a);
      br_en[a]  = 1'b0;
      br_off[a] = 4'h0;
    end
    br_en[8'h10]  = 1'b1;
    br_off[8'h10] = 4'b1101;
    br_en[8'hFC]  = 1'b1;
    br_off[8'hFC] = 4'h7;

    @(negedge clk);
    do_reset(3);
    repeat (12) step();
    lat_max = 3;
    repeat (30) step();
    ready_pct = 0;
    repeat (8) step();
    ready_pct = 70;
    for (int i = 0; i < 3000 && !wrapped; i++) step();
    check("wrap_reached", 32'(wrapped), 1);

    mem[5]    = 8'h1C;
    br_en[5]  = 1'b1;
    br_off[5] = 4'h2;
    for (int i = 0; i < 200 && m != M_HALT; i++) step();
    check("halt_reach", 32'(Halted), 1);
    repeat (25) step();

    lat_max = 8;
    do_reset(2);
    for (int i = 0; i < 50 && !(m == M_FETCH && lat > 1); i++)
      step();
    check("mid_fetch_req", 32'(IMemReq), 1);
    do_reset(2);
    ready_pct = 0;
    lat_max = 2;
    for (int i = 0; i < 50 && m != M_ISSUE; i++) step();
    check("mid_issue_valid", 32'(InstrValid), 1);
    do_reset(2);
    ready_pct = 100;
    repeat (10) step();

    dir_mode  = 1'b0;
    lat_max   = 3;
    ready_pct = 60;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      if ((m == M_HALT && $urandom_range(7) == 0) ||
          $urandom_range(499) == 0)
        do_reset(1 + $urandom_range(2));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream of the control unit; owns the program counter.
- Fetches one 8-bit instruction at a time from instruction memory over a req/ack handshake.
- Presents the instruction to the decoder with a valid/ready handshake.
- Applies PC-relative branches resolved at issue.
- Stops permanently on HALT until reset.

Parameters:
ADDR_WIDTH, 8, PC / instruction-memory address width; PC wraps modulo 2^ADDR_WIDTH
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 4'b0001, opcode (Instruction[7:4]) that halts fetch

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
IMemReq  out  1  fetch request; held until IMemAck
IMemAddr  out  ADDR_WIDTH  fetch address (= PC); stable while IMemReq=1
IMemAck  in  1  memory response valid; meaningful only while IMemReq=1
IMemData  in  8  instruction byte; sampled when IMemReq && IMemAck
Instruction  out  8  registered instruction to control unit
InstrPC  out  ADDR_WIDTH  address Instruction was fetched from
InstrValid  out  1  Instruction valid
InstrReady  in  1  decoder accepts Instruction this cycle
BranchTaken  in  1  accepted instruction is a taken branch; sampled only on accept
BranchOffset  in  4  signed two's-complement offset, -8..+7
Halted  out  1  HALT retired; fetch stopped

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, PC=RESET_PC.
  - IMemReq=0, InstrValid=0, Instruction=8'h00, InstrPC=0, Halted=0.
  - Any outstanding memory request is abandoned; memory must tolerate a dropped request.
- States: IDLE, FETCH, ISSUE, HALTED.
  - IDLE -> FETCH unconditionally on the first edge after reset release.
  - FETCH: IMemReq=1, IMemAddr=PC.
    - IMemAck=1: capture IMemData into Instruction, PC into InstrPC; -> ISSUE.
    - IMemAck=0: stay, address held.
  - ISSUE: InstrValid=1; Instruction and InstrPC held stable until accept.
    - accept = InstrValid && InstrReady.
  - On accept, non-HALT instruction: -> FETCH.
    - PC = InstrPC + 1 if BranchTaken=0.
    - PC = InstrPC + sign_extend(BranchOffset) if BranchTaken=1.
    - Both sums are ADDR_WIDTH-bit, modulo 2^ADDR_WIDTH.
  - On accept, Instruction[7:4]==HALT_OPCODE: -> HALTED.
    - BranchTaken is ignored.
  - HALTED: IMemReq=0, InstrValid=0, Halted=1. Terminal until rst_n.
- Outputs IMemReq, InstrValid and Halted are decoded from the registered state only; no combinational path from inputs.
- BranchTaken/BranchOffset outside an accept cycle: ignored.
- IMemAck while IMemReq=0: ignored.
- Latency and throughput:
  - Reset release to first IMemReq: 1 cycle.
  - Ack to InstrValid: 1 cycle.
  - Peak throughput: 1 instruction per 2 cycles with zero-wait memory and InstrReady tied high.
- Branch with offset 0 refetches the same address (self-loop); legal.
- Wrap examples:
  - PC=8'hFF, sequential -> 8'h00.
  - InstrPC=8'h02, offset -4 -> 8'hFE.
- rst_n asserted in any state, including mid-FETCH with the ack pending or mid-ISSUE: immediate return to reset values; no partial instruction is issued.

Optional Feature:
FETCH_TRACE_EN
- Defined: a simulation-only $display fires on every accept, printing $time, InstrPC, Instruction, BranchTaken and next PC, plus a one-time "HALT at <InstrPC>" message on entry to HALTED.
- Undefined: no display statements. Cycle behaviour is identical in both cases.

Test Plan:
- Reset-to-fetch: rst_n low 3 cycles, memory acks same cycle with byte = address.
  - IMemReq rises 1 cycle after release; IMemAddr 0,1,2,3 in order.
  - InstrValid pulses with Instruction 00,01,02; InstrPC matches.
- Variable latency: acks delayed 0,3,1 cycles.
  - IMemAddr stable throughout each wait; each instruction issued exactly once, in order.
- Backpressure: InstrReady low 5 cycles while InstrValid=1.
  - Instruction/InstrPC unchanged; no IMemReq until accept.
- Branches: accept at InstrPC=8'h10 with BranchTaken=1, BranchOffset=4'b1101 (-3) -> next IMemAddr=8'h0D.
  - Offset +7 from 8'hFC -> 8'h03 (wrap).
  - BranchTaken=1 on a non-accept cycle -> no effect.
- HALT: memory returns 8'h1x at address 5.
  - Issued with InstrValid; after accept Halted=1, IMemReq=0, InstrValid=0 for 20+ cycles.
  - BranchTaken=1 on the HALT accept -> ignored.
- Reset mid-operation: rst_n low while in FETCH awaiting ack, and again while in ISSUE.
  - All outputs at reset values in the same cycle; after release, fetch restarts at RESET_PC.
